// File: rtl/shunt_hs_array_deframer.sv
// Receive-side deframer for the handshake array transfer protocol: validates per-row
// 4-word headers and emits payload words tagged with row/column and last markers.
module shunt_hs_array_deframer #(
   parameter  int DATA_W       = 64,
   parameter  int MAX_ROWS     = 256,
   parameter  int MAX_PAYLOADS = 1024,
   localparam int NR_W  = $clog2(MAX_ROWS + 1),
   localparam int ROW_W = $clog2(MAX_ROWS),
   localparam int COL_W = $clog2(MAX_PAYLOADS),
   localparam int NP_W  = $clog2(MAX_PAYLOADS + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [NR_W-1:0]   cfg_n_rows_i,
   input  logic [31:0]       cfg_data_type_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [ROW_W-1:0]  out_row_o,
   output logic [COL_W-1:0]  out_col_o,
   output logic              out_last_row_o,
   output logic              out_last_array_o,
   output logic [31:0]       trnx_type_o,
   output logic [31:0]       trnx_id_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_len_o,
   output logic              err_id_o,
   output logic              err_type_o
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DRAIN} state_t;

   localparam logic [31:0] MAXP32 = 32'(MAX_PAYLOADS);

   state_t              state_q;
   logic [1:0]          hcnt_q;
   logic [31:0]         hdr_type_q, hdr_id_q, hdr_dt_q;
   logic [31:0]         cfg_dt_q;
   logic [NR_W-1:0]     n_rows_q;
   logic [ROW_W-1:0]    row_q;
   logic [COL_W-1:0]    col_q;
   logic [NP_W-1:0]     npay_q;
   logic                out_valid_q, out_last_row_q, out_last_array_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [ROW_W-1:0]    out_row_q;
   logic [COL_W-1:0]    out_col_q;
   logic [31:0]         trnx_type_q, trnx_id_q;
   logic                busy_q, done_q, err_len_q, err_id_q, err_type_q;

   logic                in_fire, out_fire;
   logic [31:0]         n_pay;
   logic                bad_len, bad_type, bad_id, hdr_ok;
   logic                last_col, last_row;

   always_comb begin
      in_ready_o = (state_q == S_HDR) ||
                   ((state_q == S_PAYLOAD) && (!out_valid_q || out_ready_i));
      in_fire    = in_valid_i && in_ready_o;
      out_fire   = out_valid_q && out_ready_i;
      n_pay      = in_data_i[31:0];
      bad_len    = (n_pay == 32'd0) || (n_pay > MAXP32);
      bad_type   = (hdr_dt_q != cfg_dt_q);
      // Row 0 has no reference id yet; later rows must match the one latched from it.
      bad_id     = (row_q != '0) && (hdr_id_q != trnx_id_q);
      hdr_ok     = !(bad_len || bad_type || bad_id);
      last_col   = (NP_W'(col_q) == (npay_q - NP_W'(1)));
      last_row   = (NR_W'(row_q) == (n_rows_q - NR_W'(1)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q          <= S_IDLE;
         hcnt_q           <= '0;
         hdr_type_q       <= '0;
         hdr_id_q         <= '0;
         hdr_dt_q         <= '0;
         cfg_dt_q         <= '0;
         n_rows_q         <= '0;
         row_q            <= '0;
         col_q            <= '0;
         npay_q           <= '0;
         out_valid_q      <= 1'b0;
         out_data_q       <= '0;
         out_row_q        <= '0;
         out_col_q        <= '0;
         out_last_row_q   <= 1'b0;
         out_last_array_q <= 1'b0;
         trnx_type_q      <= '0;
         trnx_id_q        <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         err_len_q        <= 1'b0;
         err_id_q         <= 1'b0;
         err_type_q       <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         err_len_q  <= 1'b0;
         err_id_q   <= 1'b0;
         err_type_q <= 1'b0;
         if (out_fire) out_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  n_rows_q <= (cfg_n_rows_i == '0) ? NR_W'(1) : cfg_n_rows_i;
                  cfg_dt_q <= cfg_data_type_i;
                  row_q    <= '0;
                  col_q    <= '0;
                  hcnt_q   <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_HDR;
               end
            end
            S_HDR: begin
               if (in_fire) begin
                  hcnt_q <= hcnt_q + 2'd1;
                  case (hcnt_q)
                     2'd0: hdr_type_q <= in_data_i[31:0];
                     2'd1: hdr_id_q   <= in_data_i[31:0];
                     2'd2: hdr_dt_q   <= in_data_i[31:0];
                     default: begin
                        err_len_q  <= bad_len;
                        err_id_q   <= bad_id;
                        err_type_q <= bad_type;
                        if (hdr_ok) begin
                           npay_q  <= n_pay[NP_W-1:0];
                           col_q   <= '0;
                           state_q <= S_PAYLOAD;
                           if (row_q == '0) begin
                              trnx_type_q <= hdr_type_q;
                              trnx_id_q   <= hdr_id_q;
                           end
                        end
                     end
                  endcase
               end
            end
            S_PAYLOAD: begin
               if (in_fire) begin
                  out_valid_q      <= 1'b1;
                  out_data_q       <= in_data_i;
                  out_row_q        <= row_q;
                  out_col_q        <= col_q;
                  out_last_row_q   <= last_col;
                  out_last_array_q <= last_col && last_row;
                  if (last_col) begin
                     if (last_row) begin
                        state_q <= S_DRAIN;
                     end else begin
                        row_q   <= row_q + ROW_W'(1);
                        hcnt_q  <= '0;
                        state_q <= S_HDR;
                     end
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // Only the end-of-array word can be in the output register here.
               if (out_fire) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid_o      = out_valid_q;
   assign out_data_o       = out_data_q;
   assign out_row_o        = out_row_q;
   assign out_col_o        = out_col_q;
   assign out_last_row_o   = out_last_row_q;
   assign out_last_array_o = out_last_array_q;
   assign trnx_type_o      = trnx_type_q;
   assign trnx_id_o        = trnx_id_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign err_len_o        = err_len_q;
   assign err_id_o         = err_id_q;
   assign err_type_o       = err_type_q;

endmodule

// File: tb/tb_shunt_hs_array_deframer.sv
// Bench for shunt_hs_array_deframer: a queue-based transfer model builds the input word
// stream and the expected tagged outputs; each scenario task checks the DUT against it.
module tb_shunt_hs_array_deframer;
   localparam int MAXP = 1024;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, out_ready;
   logic [8:0]  cfg_n_rows;
   logic [31:0] cfg_dt;
   logic [63:0] in_data;
   logic        in_ready, out_valid, olr, ola, busy, done, el, ei, et;
   logic [63:0] out_data;
   logic [7:0]  out_row;
   logic [9:0]  out_col;
   logic [31:0] ttype, tid;

   shunt_hs_array_deframer dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_n_rows_i(cfg_n_rows),
      .cfg_data_type_i(cfg_dt), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_row_o(out_row), .out_col_o(out_col),
      .out_last_row_o(olr), .out_last_array_o(ola), .trnx_type_o(ttype),
      .trnx_id_o(tid), .busy_o(busy), .done_o(done), .err_len_o(el),
      .err_id_o(ei), .err_type_o(et));

   always #5 clk = ~clk;

   typedef struct { logic [63:0] d; int row; int col; bit lr; bit la; } exp_t;
   exp_t        exp_q[$];
   logic [63:0] in_q[$];
   int          kind_q[$];   // -2 payload, -1 header word 0..2, >=0 header word 3 with error mask
   int          total = 0, bad = 0;
   int          m_row, m_nrows;
   logic [31:0] m_dt, m_id0, m_ty0;

   task automatic model_start(input int nr, input logic [31:0] dt);
      m_nrows = (nr == 0) ? 1 : nr;
      m_dt = dt; m_row = 0; m_id0 = 0; m_ty0 = 0;
      exp_q.delete(); in_q.delete(); kind_q.delete();
   endtask

   task automatic add_row(input logic [31:0] ty, input logic [31:0] id,
                          input logic [31:0] dt, input logic [31:0] n);
      logic [2:0] m;
      exp_t e;
      m[2] = (n == 0) || (n > MAXP);
      m[1] = (m_row > 0) && (id != m_id0);
      m[0] = (dt != m_dt);
      in_q.push_back({$urandom, ty}); kind_q.push_back(-1);
      in_q.push_back({$urandom, id}); kind_q.push_back(-1);
      in_q.push_back({$urandom, dt}); kind_q.push_back(-1);
      in_q.push_back({$urandom, n});  kind_q.push_back(int'(m));
      if (m == 3'b000) begin
         if (m_row == 0) begin m_id0 = id; m_ty0 = ty; end
         for (int c = 0; c < int'(n); c++) begin
            e.d = {$urandom, $urandom};
            e.row = m_row; e.col = c;
            e.lr = (c == int'(n) - 1);
            e.la = e.lr && (m_row == m_nrows - 1);
            in_q.push_back(e.d); kind_q.push_back(-2);
            exp_q.push_back(e);
         end
         m_row++;
      end
   endtask

   task automatic do_start(input int nr, input logic [31:0] dt);
      @(negedge clk);
      in_valid = 1'b0; start = 1'b1; cfg_n_rows = 9'(nr); cfg_dt = dt;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode: 0 = always ready, 1 = out_ready toggling 1010..., 2 = random valid/ready
   task automatic run_xfer(input int max_cyc, input int mode);
      bit          exp_done = 0, seen_done = 0, stall = 0, tog = 1, exp_rdy;
      logic [2:0]  exp_err = 3'b000;
      logic [63:0] sd; logic [7:0] sr; logic [9:0] sc; logic slr, sla;
      int          cyc = 0, k;
      exp_t        e;
      while (!seen_done && cyc < max_cyc) begin
         @(negedge clk); cyc++;
         total++;
         if ({el, ei, et} !== exp_err) begin
            bad++; $display("FAIL err_pulse cyc=%0d got=%b exp=%b", cyc, {el, ei, et}, exp_err);
         end
         total++;
         if (done !== exp_done || busy !== !exp_done) begin
            bad++; $display("FAIL done_busy cyc=%0d got done=%b busy=%b exp done=%b busy=%b",
                            cyc, done, busy, exp_done, !exp_done);
         end
         if (stall) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== sd || out_row !== sr || out_col !== sc ||
                olr !== slr || ola !== sla) begin
               bad++; $display("FAIL stall_stable cyc=%0d got=%h/%0d/%0d exp=%h/%0d/%0d",
                               cyc, out_data, out_row, out_col, sd, sr, sc);
            end
         end
         if (exp_done) seen_done = 1;
         exp_err = 3'b000; exp_done = 0;
         if (!seen_done) begin
            in_valid = (in_q.size() > 0) && (mode != 2 || $urandom_range(3) != 0);
            in_data  = (in_q.size() > 0) ? in_q[0] : {$urandom, $urandom};
            case (mode)
               0:       out_ready = 1'b1;
               1:       begin out_ready = tog; tog = !tog; end
               default: out_ready = ($urandom_range(1) == 1);
            endcase
            #1;
            if (in_q.size() > 0) begin
               exp_rdy = (kind_q[0] == -2) ? (!out_valid || out_ready) : 1'b1;
               total++;
               if (in_ready !== exp_rdy) begin
                  bad++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
               end
            end
            if (out_valid && out_ready) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++; $display("FAIL extra_output cyc=%0d got=%h exp=none", cyc, out_data);
               end else begin
                  e = exp_q.pop_front();
                  if (out_data !== e.d || out_row !== 8'(e.row) || out_col !== 10'(e.col) ||
                      olr !== e.lr || ola !== e.la) begin
                     bad++;
                     $display("FAIL out_word cyc=%0d got=%h r%0d c%0d lr%b la%b exp=%h r%0d c%0d lr%b la%b",
                              cyc, out_data, out_row, out_col, olr, ola, e.d, e.row, e.col, e.lr, e.la);
                  end
                  if (e.la) exp_done = 1;
               end
            end
            if (in_valid && in_ready) begin
               void'(in_q.pop_front());
               k = kind_q.pop_front();
               if (k >= 0) exp_err = 3'(k);
            end
            stall = out_valid && !out_ready;
            sd = out_data; sr = out_row; sc = out_col; slr = olr; sla = ola;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++;
      if (!seen_done || exp_q.size() != 0 || in_q.size() != 0) begin
         bad++; $display("FAIL xfer_complete got done=%b left_out=%0d left_in=%0d exp done=1 left=0",
                         seen_done, exp_q.size(), in_q.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1'b1; in_valid = 1'b0; start = 1'b0;
      @(posedge clk); @(negedge clk);
      total++;
      if ({in_ready, out_valid, olr, ola, busy, done, el, ei, et} !== 9'd0) begin
         bad++; $display("FAIL reset_flags got=%b exp=0", {in_ready, out_valid, olr, ola, busy, done, el, ei, et});
      end
      total++;
      if (out_data !== 64'd0 || out_row !== 8'd0 || out_col !== 10'd0) begin
         bad++; $display("FAIL reset_out got=%h/%0d/%0d exp=0/0/0", out_data, out_row, out_col);
      end
      total++;
      if (ttype !== 32'd0 || tid !== 32'd0) begin
         bad++; $display("FAIL reset_trnx got=%0d/%0d exp=0/0", ttype, tid);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_row();
      model_start(1, 2);
      add_row(1, 7, 2, 4);
      do_start(1, 2);
      run_xfer(200, 0);
      total++;
      if (ttype !== 32'd1 || tid !== 32'd7) begin
         bad++; $display("FAIL single_trnx got=%0d/%0d exp=1/7", ttype, tid);
      end
   endtask

   task automatic test_multi_row();
      model_start(3, 2);
      add_row(4, 9, 2, 2); add_row(4, 9, 2, 5); add_row(4, 9, 2, 1);
      do_start(3, 2);
      run_xfer(300, 0);
      total++;
      if (tid !== 32'd9) begin
         bad++; $display("FAIL multi_trnx_id got=%0d exp=9", tid);
      end
   endtask

   task automatic test_backpressure();
      model_start(1, 11);
      add_row(2, 3, 11, 16);
      do_start(1, 11);
      run_xfer(300, 1);
   endtask

   task automatic test_hdr_errors();
      model_start(2, 2);
      add_row(1, 9, 2, 0);           // length zero
      add_row(1, 9, 2, MAXP + 1);    // length over max
      add_row(1, 9, 3, 4);           // type mismatch
      add_row(1, 9, 3, 0);           // length and type together
      add_row(1, 9, 2, 3);
      add_row(1, 8, 2, 2);           // id mismatch on row 1
      add_row(1, 9, 2, MAXP);        // exactly max length is legal
      do_start(2, 2);
      run_xfer(8000, 2);
   endtask

   task automatic test_reset_mid();
      logic [31:0] hdr [4];
      hdr[0] = 1; hdr[1] = 7; hdr[2] = 2; hdr[3] = 6;
      do_start(1, 2);
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = (i < 4) ? {32'd0, hdr[i]} : {$urandom, $urandom};
      end
      @(negedge clk); in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_col !== 10'd2) begin
         bad++; $display("FAIL mid_state got v=%b busy=%b col=%0d exp v=1 busy=1 col=2", out_valid, busy, out_col);
      end
      test_reset();
      model_start(2, 5);
      add_row(6, 21, 5, 3); add_row(6, 21, 5, 2);
      do_start(2, 5);
      run_xfer(300, 2);
   endtask

   task automatic test_start_busy();
      model_start(2, 5);
      add_row(3, 44, 5, 3); add_row(3, 44, 5, 4);
      do_start(2, 5);
      do_start(1, 6);   // ignored: busy; cfg inputs stay at the new values
      run_xfer(300, 2);
      total++;
      if (tid !== 32'd44 || ttype !== 32'd3) begin
         bad++; $display("FAIL busy_trnx got=%0d/%0d exp=3/44", ttype, tid);
      end
   endtask

   task automatic test_random();
      int nr; logic [31:0] dt, id;
      for (int it = 0; it < 4; it++) begin
         nr = (it == 0) ? 0 : $urandom_range(1, 4);
         dt = $urandom; id = $urandom;
         model_start(nr, dt);
         for (int r = 0; r < m_nrows; r++) begin
            if ($urandom_range(2) == 0) add_row(1, id, dt + 32'd1, 3);
            add_row(1, id, dt, $urandom_range(1, 12));
         end
         do_start(nr, dt);
         run_xfer(2000, 2);
         total++;
         if (tid !== m_id0) begin
            bad++; $display("FAIL rand_trnx_id got=%h exp=%h", tid, m_id0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cfg_n_rows = 0; cfg_dt = 0; in_data = 0;
      test_reset();
      test_single_row();
      test_multi_row();
      test_backpressure();
      test_hdr_errors();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
